// File: rtl/mux_channel_scanner_if.sv
// Bus between the channel scanner and its host / mux.
// Optional PARITY output is present only when MUX_SCAN_PARITY_EN is defined.
interface mux_channel_scanner_if #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
);
    logic              start;
    logic              continuous;
    logic              mux_out;
    logic [SEL_W-1:0]  select;
    logic [NUM_CH-1:0] samples;
    logic              valid;
    logic              busy;
`ifdef MUX_SCAN_PARITY_EN
    logic              parity;
`endif

`ifdef MUX_SCAN_PARITY_EN
    modport slave (
        input  start, continuous, mux_out,
        output select, samples, valid, busy, parity
    );
    modport master (
        output start, continuous, mux_out,
        input  select, samples, valid, busy, parity
    );
`else
    modport slave (
        input  start, continuous, mux_out,
        output select, samples, valid, busy
    );
    modport master (
        output start, continuous, mux_out,
        input  select, samples, valid, busy
    );
`endif
endinterface

// File: rtl/mux_channel_scanner.sv
// Sequencer in front of an NUM_CH:1 mux. Walks SELECT through every channel,
// holds each for DWELL_CYCLES, captures the mux output at the end of each
// dwell and publishes the whole sweep with a one-cycle VALID pulse.
// Optional: define MUX_SCAN_PARITY_EN to add a registered PARITY output
// (XOR of the published snapshot).
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for START; SELECT=0, BUSY=0
// ST_SCAN | sweep in progress; SELECT follows the channel index
module mux_channel_scanner #(
    parameter int NUM_CH       = 4,
    parameter int SEL_W        = 2,
    parameter int DWELL_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mux_channel_scanner_if.slave bus
);
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_CH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // The last channel bypasses the shadow and goes straight to samples,
    // so the shadow only needs NUM_CH-1 bits.
    logic [NUM_CH-2:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] samples_q, samples_d;
    logic              valid_q, valid_d;
`ifdef MUX_SCAN_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: index, dwell counter, shadow and published snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            samples_q <= '0;
            valid_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            samples_q <= samples_d;
            valid_q   <= valid_d;
`ifdef MUX_SCAN_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state and datapath update; VALID defaults low so it is a single pulse.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        samples_d = samples_q;
        valid_d   = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        samples_d = {bus.mux_out, shadow_q};
                        valid_d   = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                        parity_d  = ^{bus.mux_out, shadow_q};
`endif
                        idx_d     = '0;
                        if (!bus.continuous) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        for (int k = 0; k < NUM_CH - 1; k++) begin
                            if (idx_q == SEL_W'(k)) begin
                                shadow_d[k] = bus.mux_out;
                            end
                        end
                        idx_d = idx_q + SEL_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // SELECT is the registered index; it is held at 0 whenever the FSM idles.
    assign bus.select  = idx_q;
    assign bus.busy    = (state_q == ST_SCAN);
    assign bus.samples = samples_q;
    assign bus.valid   = valid_q;
`ifdef MUX_SCAN_PARITY_EN
    assign bus.parity  = parity_q;
`endif

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Bench for mux_channel_scanner: two instances (dwell 2 and dwell 1) fed from
// the same controls, each with its own mux pattern, compared every cycle
// against a sweep-timeline reference model, plus directed scenario checks.
module tb_mux_channel_scanner;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cont = 1'b0;
    logic [3:0] pat [2];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mux_channel_scanner_if #(.NUM_CH(4), .SEL_W(2)) if0 ();
    mux_channel_scanner_if #(.NUM_CH(4), .SEL_W(2)) if1 ();

    assign if0.start = start;
    assign if0.continuous = cont;
    assign if0.mux_out = pat[0][if0.select];
    assign if1.start = start;
    assign if1.continuous = cont;
    assign if1.mux_out = pat[1][if1.select];

    mux_channel_scanner #(.NUM_CH(4), .SEL_W(2), .DWELL_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave));
    mux_channel_scanner #(.NUM_CH(4), .SEL_W(2), .DWELL_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave));

    // Reference model: a sweep is a timeline of NUM_CH*D cycles; elapsed time
    // p determines the selected channel (p/D) and capture points (p%D==0).
    localparam int N = 4;
    int         m_busy [2];
    int         m_p [2];
    logic [3:0] m_cap [2];
    logic [3:0] m_samples [2];
    logic       m_valid [2];
    logic       m_par [2];

    function automatic int dw(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int exp_sel(int i);
        return (m_busy[i] != 0) ? m_p[i] / dw(i) : 0;
    endfunction

    task automatic model_step(int i);
        int ch;
        if (reset) begin
            m_busy[i] = 0; m_p[i] = 0; m_cap[i] = 4'b0;
            m_samples[i] = 4'b0; m_valid[i] = 1'b0; m_par[i] = 1'b0;
        end else begin
            m_valid[i] = 1'b0;
            if (m_busy[i] == 0) begin
                if (start) begin
                    m_busy[i] = 1;
                    m_p[i] = 0;
                end
            end else begin
                ch = m_p[i] / dw(i);
                m_p[i] = m_p[i] + 1;
                if (m_p[i] % dw(i) == 0) m_cap[i][ch] = pat[i][ch];
                if (m_p[i] == N * dw(i)) begin
                    m_samples[i] = m_cap[i];
                    m_valid[i] = 1'b1;
                    m_par[i] = ^m_cap[i];
                    m_p[i] = 0;
                    if (!cont) m_busy[i] = 0;
                end
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // One clock: advance model on pre-edge inputs, then compare #1 after the edge.
    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        cyc++;
        check("sel0", 32'(if0.select), 32'(exp_sel(0)));
        check("busy0", 32'(if0.busy), 32'(m_busy[0] != 0));
        check("valid0", 32'(if0.valid), 32'(m_valid[0]));
        check("samples0", 32'(if0.samples), 32'(m_samples[0]));
        check("sel1", 32'(if1.select), 32'(exp_sel(1)));
        check("busy1", 32'(if1.busy), 32'(m_busy[1] != 0));
        check("valid1", 32'(if1.valid), 32'(m_valid[1]));
        check("samples1", 32'(if1.samples), 32'(m_samples[1]));
`ifdef MUX_SCAN_PARITY_EN
        check("parity0", 32'(if0.parity), 32'(m_par[0]));
        check("parity1", 32'(if1.parity), 32'(m_par[1]));
`endif
    endtask

    initial begin
        int found;
        int v1;
        int v2;
        int nv;
        int vt [$];
        int vt1 [$];

        pat[0] = 4'b1101;
        pat[1] = 4'b1001;

        // Reset state.
        reset = 1'b1;
        tick();
        tick();
        check("rst_sel", 32'(if0.select), 32'd0);
        check("rst_busy", 32'(if0.busy), 32'd0);
        check("rst_samples", 32'(if0.samples), 32'd0);
        check("rst_valid", 32'(if0.valid), 32'd0);
        reset = 1'b0;
        tick();

        // Single-shot sweep.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 2) check("ss_sel_step", 32'(if0.select), 32'd1);
            if (k == 4) begin
                check("d1_valid_at4", 32'(if1.valid), 32'd1);
                check("d1_samples", 32'(if1.samples), 32'b1001);
            end
            if (k == 7) check("ss_no_early_valid", 32'(if0.valid), 32'd0);
            if (k == 8) begin
                check("ss_valid_at8", 32'(if0.valid), 32'd1);
                check("ss_samples", 32'(if0.samples), 32'b1101);
`ifdef MUX_SCAN_PARITY_EN
                check("ss_parity", 32'(if0.parity), 32'd1);
`endif
            end
            if (k == 9) begin
                check("ss_valid_pulse", 32'(if0.valid), 32'd0);
                check("ss_idle_busy", 32'(if0.busy), 32'd0);
                check("ss_idle_sel", 32'(if0.select), 32'd0);
            end
        end

        // Continuous mode, pattern changes before channel 0 of the second sweep.
        cont = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0; v1 = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            tick();
            if (if0.valid === 1'b1) begin found = 1; v1 = cyc; end
        end
        check("cont_first_valid", 32'(found), 32'd1);
        check("cont_first_samples", 32'(if0.samples), 32'b1101);
        check("cont_no_gap_busy", 32'(if0.busy), 32'd1);
        pat[0] = 4'b0110;
        found = 0; v2 = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            tick();
            if (if0.valid === 1'b1) begin found = 1; v2 = cyc; end
        end
        check("cont_second_valid", 32'(found), 32'd1);
        check("cont_period", 32'(v2 - v1), 32'd8);
        check("cont_second_samples", 32'(if0.samples), 32'b0110);
`ifdef MUX_SCAN_PARITY_EN
        check("cont_parity", 32'(if0.parity), 32'd0);
`endif
        cont = 1'b0;
        for (int n = 0; n < 12; n++) tick();
        check("cont_stop_busy", 32'(if0.busy), 32'd0);

        // Reset mid-sweep.
        pat[0] = 4'b1101;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_sel", 32'(if0.select), 32'd0);
        check("mid_rst_busy", 32'(if0.busy), 32'd0);
        check("mid_rst_samples", 32'(if0.samples), 32'd0);
        nv = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (if0.valid === 1'b1) nv++;
        end
        check("mid_rst_no_valid", 32'(nv), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            tick();
            if (if0.valid === 1'b1) found = 1;
        end
        check("post_rst_valid", 32'(found), 32'd1);
        check("post_rst_samples", 32'(if0.samples), 32'b1101);

        // START held high, single-shot: one idle cycle between sweeps.
        start = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (if0.valid === 1'b1) vt.push_back(cyc);
            if (if1.valid === 1'b1) vt1.push_back(cyc);
        end
        start = 1'b0;
        check("held_sweeps0", 32'(vt.size() >= 3), 32'd1);
        if (vt.size() >= 3) begin
            check("held_gap0_a", 32'(vt[1] - vt[0]), 32'd9);
            check("held_gap0_b", 32'(vt[2] - vt[1]), 32'd9);
        end
        check("held_sweeps1", 32'(vt1.size() >= 2), 32'd1);
        if (vt1.size() >= 2) check("held_gap1", 32'(vt1[1] - vt1[0]), 32'd5);
        for (int n = 0; n < 10; n++) tick();

        // Randomized controls and mux data against the model.
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) cont = ~cont;
            pat[0] = 4'($urandom);
            pat[1] = 4'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
